// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and state type for the instruction-fetch stage
package if_pkg;

  localparam int          PC_WIDTH    = 11;
  localparam int          INST_WIDTH  = 32;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam int          QUEUE_DEPTH = 2;

  // IDLE: no read in flight. BUSY: read in flight, data will be kept.
  // DROP: read in flight but made stale by a redirect, data will be discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_queue.sv
// rtl/if_queue.sv - two-entry FIFO holding fetched {instruction, next-pc} pairs
module if_queue #(
  parameter int DW = 43
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [1:0]    o_count,
  output logic          o_valid
);

  logic [DW-1:0] r_mem [2];
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_wr_ptr;

  // Write slot is the read pointer advanced by the occupancy (mod 2).
  assign w_wr_ptr = r_rd_ptr ^ r_count[0];

  // Data storage; no reset needed because occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[w_wr_ptr] <= i_din;
    end
  end

  // Occupancy and read pointer; flush empties the queue regardless of push/pop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: pc register, request FSM, credit logic, output mux
module if_stage #(
  parameter int                     PC_WIDTH   = if_pkg::PC_WIDTH,
  parameter int                     INST_WIDTH = if_pkg::INST_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0]  NOP        = if_pkg::NOP
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  IF_ID_Write,
  input  logic                  PCSrc,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] instruccion,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  if_valid
);

  import if_pkg::*;

  localparam int DW = INST_WIDTH + PC_WIDTH;

  if_state_t             r_state;
  if_state_t             w_state_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [PC_WIDTH-1:0]   w_pc_inc;
  logic [PC_WIDTH-1:0]   r_addr;
  logic [PC_WIDTH-1:0]   w_addr_next;
  logic [PC_WIDTH-1:0]   w_addr_inc;
  logic                  r_req;

  logic                  w_valid;
  logic [1:0]            w_count;
  logic [DW-1:0]         w_q_dout;
  logic [INST_WIDTH-1:0] w_head_inst;
  logic [PC_WIDTH-1:0]   w_head_pc;

  logic                  w_ack_busy;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_cnt_after;
  logic                  w_credit;

  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_addr_inc = r_addr + PC_WIDTH'(1);

  // A redirect wins over both the returning data and the downstream consume.
  assign w_ack_busy = (r_state == BUSY) && imem_ack;
  assign w_push     = w_ack_busy && !PCSrc;
  assign w_pop      = IF_ID_Write && w_valid && !PCSrc;

  // Occupancy after this edge; a completing read is counted either as pushed
  // data or as the still-outstanding slot, so it always occupies one credit.
  assign w_cnt_after = w_count - {1'b0, w_pop} + {1'b0, w_ack_busy};
  assign w_credit    = (w_cnt_after < 2'(QUEUE_DEPTH));

  // Next-state, next-pc and next-address decisions for the request FSM.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_addr_next  = r_addr;
    case (r_state)
      IDLE: begin
        if (PCSrc) begin
          w_pc_next = branch_target;
        end else if (w_credit) begin
          w_state_next = BUSY;
          w_addr_next  = r_pc;
        end
      end
      BUSY: begin
        if (PCSrc) begin
          w_pc_next    = branch_target;
          // If the read completes on the redirect edge nothing is left to drop.
          w_state_next = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          w_pc_next = w_pc_inc;
          if (w_credit) begin
            w_addr_next = w_pc_inc;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (PCSrc) begin
          w_pc_next = branch_target;
        end
        if (imem_ack) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, pc and registered memory-request outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_addr  <= w_addr_next;
      r_req   <= (w_state_next != IDLE);
    end
  end

  if_queue #(
    .DW(DW)
  ) u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (PCSrc),
    .i_din   ({imem_data, w_addr_inc}),
    .o_dout  (w_q_dout),
    .o_count (w_count),
    .o_valid (w_valid)
  );

  assign {w_head_inst, w_head_pc} = w_q_dout;

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign if_valid    = w_valid;
  assign instruccion = w_valid ? w_head_inst : NOP;
  assign pc          = w_valid ? w_head_pc : '0;

endmodule
